// File: rtl/fft_tf_sequencer.sv
// Twiddle-factor address sequencer for one FFT pass: emits quarter-wave ROM address and quadrant flags per point.
// Define TF_SEQ_BITREV_EN to walk the points in bit-reversed order (count still reports the natural index).
module fft_tf_sequencer #(
  parameter int log2_transform_length = 15,
  parameter int transform_length      = 32768
) (
  input  logic                             clk_fft,
  input  logic                             reset,
  input  logic                             start,
  input  logic [3:0]                       stage,
  input  logic                             advance,
  output logic                             busy,
  output logic                             done,
  output logic                             tf_valid,
  output logic [log2_transform_length-1:0] count,
  output logic [log2_transform_length-3:0] rom_add,
  output logic                             quadrant_2_3,
  output logic                             quadrant_3_4,
  output logic                             tf_sp
);

  localparam int L = log2_transform_length;
  localparam logic [L-1:0] last_j = L'(transform_length - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [L-1:0] j_q, j_d;
  logic [3:0]   s_q, s_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         tf_valid_q, tf_valid_d;
  logic [L-1:0] count_q, count_d;
  logic [L-3:0] rom_add_q, rom_add_d;
  logic         quadrant_2_3_q, quadrant_2_3_d;
  logic         quadrant_3_4_q, quadrant_3_4_d;
  logic         tf_sp_q, tf_sp_d;

  logic [L-1:0] j_perm;
  logic [L-1:0] exponent;
  logic         adv_ok;

  always_comb begin
`ifdef TF_SEQ_BITREV_EN
    j_perm = '0;
    for (int i = 0; i < L; i++) begin
      j_perm[i] = j_q[L-1-i];
    end
`else
    j_perm = j_q;
`endif
    // Shifting by the stage and truncating to L bits is the "modulo N" of the exponent.
    exponent = j_perm << s_q;
  end

  always_comb begin
    state_d        = state_q;
    j_d            = j_q;
    s_d            = s_q;
    tf_valid_d     = 1'b0;
    count_d        = count_q;
    rom_add_d      = rom_add_q;
    quadrant_2_3_d = quadrant_2_3_q;
    quadrant_3_4_d = quadrant_3_4_q;
    tf_sp_d        = tf_sp_q;
    adv_ok         = (state_q == RUN) && advance;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          j_d     = '0;
          s_d     = ({28'd0, stage} > 32'(L - 1)) ? 4'(L - 1) : stage;
        end
      end
      RUN: begin
        if (advance) begin
          if (j_q == last_j) begin
            state_d = FIN;
          end else begin
            j_d = j_q + L'(1);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (adv_ok) begin
      tf_valid_d     = 1'b1;
      count_d        = j_q;
      rom_add_d      = exponent[L-3:0];
      quadrant_2_3_d = exponent[L-1] ^ exponent[L-2];
      quadrant_3_4_d = exponent[L-1];
      tf_sp_d        = (exponent[L-3:0] == '0);
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk_fft) begin
    if (reset) begin
      state_q        <= IDLE;
      j_q            <= '0;
      s_q            <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      tf_valid_q     <= 1'b0;
      count_q        <= '0;
      rom_add_q      <= '0;
      quadrant_2_3_q <= 1'b0;
      quadrant_3_4_q <= 1'b0;
      tf_sp_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      j_q            <= j_d;
      s_q            <= s_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      tf_valid_q     <= tf_valid_d;
      count_q        <= count_d;
      rom_add_q      <= rom_add_d;
      quadrant_2_3_q <= quadrant_2_3_d;
      quadrant_3_4_q <= quadrant_3_4_d;
      tf_sp_q        <= tf_sp_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign tf_valid     = tf_valid_q;
  assign count        = count_q;
  assign rom_add      = rom_add_q;
  assign quadrant_2_3 = quadrant_2_3_q;
  assign quadrant_3_4 = quadrant_3_4_q;
  assign tf_sp        = tf_sp_q;

endmodule

// File: tb/tb_fft_tf_sequencer.sv
// Bench for fft_tf_sequencer at N=16: directed passes pinned by hand values plus random traffic vs a reference model.
// The reference model honours TF_SEQ_BITREV_EN the same way the design does.
module tb_fft_tf_sequencer;

  localparam int L = 4;
  localparam int N = 16;

  logic         clk_fft = 1'b0;
  logic         reset   = 1'b1;
  logic         start   = 1'b0;
  logic [3:0]   stage   = 4'd0;
  logic         advance = 1'b0;
  logic         busy, done, tf_valid;
  logic [L-1:0] count;
  logic [L-3:0] rom_add;
  logic         quadrant_2_3, quadrant_3_4, tf_sp;

  always #5 clk_fft = ~clk_fft;

  fft_tf_sequencer #(
    .log2_transform_length(L),
    .transform_length(N)
  ) dut (
    .clk_fft(clk_fft),
    .reset(reset),
    .start(start),
    .stage(stage),
    .advance(advance),
    .busy(busy),
    .done(done),
    .tf_valid(tf_valid),
    .count(count),
    .rom_add(rom_add),
    .quadrant_2_3(quadrant_2_3),
    .quadrant_3_4(quadrant_3_4),
    .tf_sp(tf_sp)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: a pass is "active" until its last point, then one finishing cycle.
  bit m_active = 1'b0;
  bit m_fin    = 1'b0;
  int m_j = 0;
  int m_s = 0;
  int exp_busy = 0, exp_done = 0, exp_valid = 0, exp_count = 0;
  int exp_rom = 0, exp_q23 = 0, exp_q34 = 0, exp_sp = 0;

  function automatic int bitrev(input int x);
    int r = 0;
    int v = x;
    for (int i = 0; i < L; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic modelStep(input bit st, input int stg, input bit adv, input bit rst);
    int jp, e, quad;
    exp_valid = 0;
    exp_done  = 0;
    if (rst) begin
      m_active = 0; m_fin = 0; m_j = 0; m_s = 0;
      exp_busy = 0; exp_count = 0; exp_rom = 0;
      exp_q23 = 0; exp_q34 = 0; exp_sp = 0;
      return;
    end
    if (m_fin) begin
      m_fin    = 0;
      m_active = 0;
    end else if (!m_active) begin
      if (st) begin
        m_active = 1;
        m_j = 0;
        m_s = (stg > L - 1) ? L - 1 : stg;
      end
    end else if (adv) begin
`ifdef TF_SEQ_BITREV_EN
      jp = bitrev(m_j);
`else
      jp = m_j;
`endif
      e    = (jp * (1 << m_s)) % N;
      quad = e / (N / 4);
      exp_valid = 1;
      exp_count = m_j;
      exp_rom   = e % (N / 4);
      exp_q23   = (quad == 1 || quad == 2) ? 1 : 0;
      exp_q34   = (quad >= 2) ? 1 : 0;
      exp_sp    = (exp_rom == 0) ? 1 : 0;
      if (m_j == N - 1) begin
        m_fin    = 1;
        exp_done = 1;
      end else begin
        m_j++;
      end
    end
    exp_busy = (m_active || m_fin) ? 1 : 0;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit st, input int stg, input bit adv, input bit rst);
    start   = st;
    stage   = stg[3:0];
    advance = adv;
    reset   = rst;
    @(posedge clk_fft);
    modelStep(st, stg, adv, rst);
    #1;
  endtask

  always @(negedge clk_fft) begin
    if (chk_en) begin
      checkOutput("busy", int'(busy), exp_busy);
      checkOutput("done", int'(done), exp_done);
      checkOutput("tf_valid", int'(tf_valid), exp_valid);
      checkOutput("count", int'(count), exp_count);
      checkOutput("rom_add", int'(rom_add), exp_rom);
      checkOutput("quadrant_2_3", int'(quadrant_2_3), exp_q23);
      checkOutput("quadrant_3_4", int'(quadrant_3_4), exp_q34);
      checkOutput("tf_sp", int'(tf_sp), exp_sp);
    end
  end

  initial begin
    applyStimulus(0, 0, 0, 1);
    chk_en = 1'b1;
    applyStimulus(1, 5, 1, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_count", int'(count), 0);
    checkOutput("reset_tf_valid", int'(tf_valid), 0);

    // Stage 0, advance held for the whole pass.
    applyStimulus(1, 0, 0, 0);
    checkOutput("start_busy", int'(busy), 1);
    for (int k = 0; k < N; k++) begin
      applyStimulus(0, 0, 1, 0);
      checkOutput("s0_tf_valid", int'(tf_valid), 1);
      checkOutput("s0_count", int'(count), k);
`ifdef TF_SEQ_BITREV_EN
      if (k == 4) checkOutput("s0br_rom_k4", int'(rom_add), 2);
      if (k == 8) checkOutput("s0br_rom_k8", int'(rom_add), 1);
      if (k == 12) checkOutput("s0br_rom_k12", int'(rom_add), 3);
`else
      if (k == 5) begin
        checkOutput("s0_rom_k5", int'(rom_add), 1);
        checkOutput("s0_q23_k5", int'(quadrant_2_3), 1);
        checkOutput("s0_q34_k5", int'(quadrant_3_4), 0);
        checkOutput("s0_sp_k5", int'(tf_sp), 0);
      end
      if (k == 8) begin
        checkOutput("s0_rom_k8", int'(rom_add), 0);
        checkOutput("s0_q34_k8", int'(quadrant_3_4), 1);
        checkOutput("s0_sp_k8", int'(tf_sp), 1);
      end
      if (k == 15) begin
        checkOutput("s0_rom_k15", int'(rom_add), 3);
        checkOutput("s0_q23_k15", int'(quadrant_2_3), 0);
      end
`endif
      if (k == 15) checkOutput("s0_done_k15", int'(done), 1);
      else checkOutput("s0_nodone", int'(done), 0);
    end
    applyStimulus(0, 0, 1, 0);
    checkOutput("fin_exit_busy", int'(busy), 0);
    checkOutput("fin_exit_valid", int'(tf_valid), 0);

    // Stage 2, start and advance together in IDLE: advance must be ignored.
    applyStimulus(1, 2, 1, 0);
    checkOutput("start_adv_valid", int'(tf_valid), 0);
    for (int k = 0; k < N; k++) begin
      applyStimulus(0, 0, 1, 0);
`ifndef TF_SEQ_BITREV_EN
      if (k == 2) begin
        checkOutput("s2_rom_k2", int'(rom_add), 0);
        checkOutput("s2_q34_k2", int'(quadrant_3_4), 1);
        checkOutput("s2_sp_k2", int'(tf_sp), 1);
      end
`endif
    end
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Toggled advance with an ignored start (stage 9) mid-pass.
    applyStimulus(1, 0, 0, 0);
    for (int t = 0; t < 2 * N; t++) begin
      applyStimulus((t == 11) ? 1'b1 : 1'b0, 9, (t % 2 == 0) ? 1'b1 : 1'b0, 0);
      if (t % 2 == 1) checkOutput("toggle_gap_valid", int'(tf_valid), 0);
      if (t == 30) checkOutput("toggle_done", int'(done), 1);
    end
    applyStimulus(0, 0, 0, 0);

    // Stage 9 clamps to 3, then reset at count 7 aborts the pass.
    applyStimulus(1, 9, 0, 0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, 1, 0);
`ifndef TF_SEQ_BITREV_EN
      if (k == 1) begin
        checkOutput("clamp_rom_k1", int'(rom_add), 0);
        checkOutput("clamp_q34_k1", int'(quadrant_3_4), 1);
        checkOutput("clamp_q23_k1", int'(quadrant_2_3), 1);
      end
`endif
    end
    checkOutput("pre_reset_count", int'(count), 7);
    applyStimulus(1, 0, 1, 1);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_count", int'(count), 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("abort_idle_valid", int'(tf_valid), 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("restart_count", int'(count), 0);
    checkOutput("restart_valid", int'(tf_valid), 1);

    for (int c = 0; c < 4000; c++) begin
      applyStimulus(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                    int'($urandom_range(0, 15)),
                    ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end

    @(negedge clk_fft);
    #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
